axicb_mst_switch_wr_nm: RTL

Parametrised write-path master switch for the AXI crossbar, successor to the fixed four-master write switch. Arbitrates AW requests from MST_NB masters, from 2 to 16, toward one slave port. Arbitration uses 4-level static priority with round-robin inside each level. An order FIFO lets AW run ahead of W while W beats still follow AW grant order. B responses route back by ID-mask decode, and responses that match no master are absorbed and flagged.

---
 rtl/axicb_mst_switch_wr_nm.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/axicb_mst_switch_wr_nm.sv
// Write-path master switch: N masters onto one slave port. AW arbitration is
// 4-level static priority with round-robin ties; W follows AW grant order.
module axicb_mst_switch_wr_nm #(
  parameter int                         AXI_ID_W     = 8,
  parameter int                         MST_NB       = 4,
  parameter logic [MST_NB*AXI_ID_W-1:0] MST_ID_MASK  = '0,
  parameter logic [AXI_ID_W-1:0]        MST_ID_SEL   = 'hF0,
  parameter logic [MST_NB*2-1:0]        MST_PRIORITY = '0,
  parameter int                         ORDER_DEPTH  = 4,
  parameter int                         AWCH_W       = 8,
  parameter int                         WCH_W        = 8,
  parameter int                         BCH_W        = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [MST_NB-1:0]        i_awvalid,
  output logic [MST_NB-1:0]        i_awready,
  input  logic [MST_NB*AWCH_W-1:0] i_awch,
  input  logic [MST_NB-1:0]        i_wvalid,
  output logic [MST_NB-1:0]        i_wready,
  input  logic [MST_NB-1:0]        i_wlast,
  input  logic [MST_NB*WCH_W-1:0]  i_wch,
  output logic [MST_NB-1:0]        i_bvalid,
  input  logic [MST_NB-1:0]        i_bready,
  output logic [BCH_W-1:0]         i_bch,
  output logic                     o_awvalid,
  input  logic                     o_awready,
  output logic [AWCH_W-1:0]        o_awch,
  output logic                     o_wvalid,
  input  logic                     o_wready,
  output logic                     o_wlast,
  output logic [WCH_W-1:0]         o_wch,
  input  logic                     o_bvalid,
  output logic                     o_bready,
  input  logic [BCH_W-1:0]         o_bch,
  output logic                     o_bid_miss
);

  localparam int                IDX_W = $clog2(MST_NB);
  localparam int                PTR_W = $clog2(ORDER_DEPTH);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(MST_NB - 1);

  typedef enum logic {ARB, HOLD} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_hold_idx;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_fifo [ORDER_DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             r_bid_miss;

  logic [IDX_W-1:0] w_arb_idx;
  logic [IDX_W-1:0] w_gnt;
  logic [IDX_W-1:0] w_head;
  logic [IDX_W-1:0] w_bidx;
  logic [1:0]       w_lvl;
  logic [1:0]       w_best_lvl;
  logic             w_any;
  logic             w_full;
  logic             w_empty;
  logic             w_aw_hs;
  logic             w_pop;
  logic             w_bhit;
  int               w_dist;
  int               w_best_dist;

  // Highest priority level wins; within a level, smallest distance from rr_ptr.
  always_comb begin
    w_arb_idx   = '0;
    w_any       = 1'b0;
    w_lvl       = 2'd0;
    w_best_lvl  = 2'd0;
    w_dist      = 0;
    w_best_dist = 0;
    for (int i = 0; i < MST_NB; i++) begin
      if (i_awvalid[i]) begin
        w_lvl  = MST_PRIORITY[2*i +: 2];
        w_dist = (i >= int'(r_rr_ptr)) ? i - int'(r_rr_ptr) : i + MST_NB - int'(r_rr_ptr);
        if (!w_any || w_lvl > w_best_lvl || (w_lvl == w_best_lvl && w_dist < w_best_dist)) begin
          w_any       = 1'b1;
          w_best_lvl  = w_lvl;
          w_best_dist = w_dist;
          w_arb_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) && (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_gnt   = (r_state == HOLD) ? r_hold_idx : w_arb_idx;

  assign o_awvalid = ((r_state == HOLD) ? i_awvalid[r_hold_idx] : w_any) & ~w_full;
  assign o_awch    = i_awch[w_gnt*AWCH_W +: AWCH_W];
  assign w_aw_hs   = o_awvalid & o_awready;

  always_comb begin
    i_awready        = '0;
    i_awready[w_gnt] = o_awready & ~w_full & i_awvalid[w_gnt];
  end

  assign w_head   = r_fifo[r_rptr[PTR_W-1:0]];
  assign o_wvalid = ~w_empty & i_wvalid[w_head];
  assign o_wch    = i_wch[w_head*WCH_W +: WCH_W];
  assign o_wlast  = i_wlast[w_head];
  assign w_pop    = o_wvalid & o_wready & o_wlast;

  always_comb begin
    i_wready         = '0;
    i_wready[w_head] = ~w_empty & o_wready;
  end

  // Descending scan so the lowest matching master is the one left standing.
  always_comb begin
    w_bhit = 1'b0;
    w_bidx = '0;
    for (int i = MST_NB - 1; i >= 0; i--) begin
      if ((o_bch[AXI_ID_W-1:0] & MST_ID_SEL) == (MST_ID_MASK[i*AXI_ID_W +: AXI_ID_W] & MST_ID_SEL)) begin
        w_bhit = 1'b1;
        w_bidx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    i_bvalid         = '0;
    i_bvalid[w_bidx] = o_bvalid & w_bhit;
  end

  assign o_bready   = w_bhit ? i_bready[w_bidx] : 1'b1;
  assign i_bch      = o_bch;
  assign o_bid_miss = r_bid_miss;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ARB;
      r_hold_idx <= '0;
      r_rr_ptr   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_bid_miss <= 1'b0;
    end else begin
      r_bid_miss <= o_bvalid & ~w_bhit;
      case (r_state)
        ARB:  if (o_awvalid && !o_awready) begin
                r_state    <= HOLD;
                r_hold_idx <= w_arb_idx;
              end
        HOLD: if (w_aw_hs) r_state <= ARB;
        default: r_state <= ARB;
      endcase
      if (w_aw_hs) begin
        r_rr_ptr <= (w_gnt == LAST) ? '0 : w_gnt + 1'b1;
        r_wptr   <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Order storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge aclk) begin
    if (w_aw_hs) r_fifo[r_wptr[PTR_W-1:0]] <= w_gnt;
  end

endmodule
